// File: rtl/divider32_pkg.sv
// Shared definitions for the iterative restoring divider.
package divider32_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/divider32_sub_borrow.sv
// Combinational ripple subtractor: a - b as a + ~b + 1, borrow is the inverted carry out.
module sub_borrow #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b1;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic b_inv;
    assign b_inv         = ~b[gi];
    assign diff[gi]      = a[gi] ^ b_inv ^ carry[gi];
    assign carry[gi + 1] = (a[gi] & b_inv) | (carry[gi] & (a[gi] ^ b_inv));
  end

  assign borrow = ~carry[WIDTH];

endmodule

// File: rtl/divider32.sv
// Iterative restoring divider, one quotient bit per clock, RISC-V M-extension
// signed, divide-by-zero and overflow behaviour.
module divider32
  import divider32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t state, state_next;

  // dvd doubles as the quotient register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  logic [WIDTH-1:0] dvd, dvs, rem, orig_dvd;
  logic [CNT_W-1:0] cnt;
  logic             q_neg, r_neg, div0;

  logic [WIDTH:0]   shifted, trial;
  logic             borrow;
  logic             unused_trial_msb;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;

  assign shifted = {rem, dvd[WIDTH-1]};

  sub_borrow #(.WIDTH(WIDTH + 1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs}),
    .diff   (trial),
    .borrow (borrow)
  );

  // With no borrow the trial is below dvs, so its top bit is always zero.
  assign unused_trial_msb = trial[WIDTH];

  assign dividend_mag = (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
  assign divisor_mag  = (is_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      orig_dvd  <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      div0      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            dvd      <= dividend_mag;
            dvs      <= divisor_mag;
            orig_dvd <= dividend;
            rem      <= '0;
            cnt      <= CNT_W'(WIDTH - 1);
            q_neg    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg    <= is_signed & dividend[WIDTH-1];
            div0     <= (divisor == '0);
          end
        end
        CALC: begin
          rem <= borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], ~borrow};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (div0) begin
            quotient  <= '1;
            remainder <= orig_dvd;
          end else begin
            quotient  <= q_neg ? (~dvd + 1'b1) : dvd;
            remainder <= r_neg ? (~rem + 1'b1) : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider32.sv
// Self-checking bench for divider32: directed corner cases, randomized
// operations against a plain-arithmetic model, handshake and reset behaviour.
module tb_divider32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int tests = 0;
  int fails = 0;

  localparam int LAT = 33;  // edges from the start edge to the edge that raises done

  divider32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  // Reference: RISC-V DIV/DIVU/REM/REMU semantics from plain arithmetic.
  function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  // Launches one operation at the next falling edge and follows it to done.
  // poke_at >= 0 raises start again (with junk operands) after that many edges.
  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input int poke_at,
                       output logic [31:0] q, output logic [31:0] r,
                       output int done_edge, output bit busy_ok, output bit busy_at_done);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    done_edge    = -1;
    busy_ok      = 1'b1;
    busy_at_done = 1'b0;
    q = 'x;
    r = 'x;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        done_edge    = k;
        busy_at_done = busy;
        q            = quotient;
        r            = remainder;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (k == poke_at) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, quotient, remainder} !== 66'd0) begin
      fails++;
      $display("FAIL reset_hold: busy=%0b done=%0b q=%h r=%h, want all 0", busy, done, quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({busy, done, quotient, remainder} !== 66'd0) begin
      fails++;
      $display("FAIL reset_release: busy=%0b done=%0b q=%h r=%h, want all 0", busy, done, quotient, remainder);
    end
  endtask

  task automatic test_directed();
    vec_t        vecs[7];
    logic [31:0] q, r;
    int          de;
    bit          bok, bdone;
    vecs[0] = '{1'b0, 32'd100,        32'd7,         32'd14,        32'd2};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    vecs[3] = '{1'b0, 32'h1234,       32'd0,         32'hFFFF_FFFF, 32'h1234};
    vecs[4] = '{1'b1, 32'h1234,       32'd0,         32'hFFFF_FFFF, 32'h1234};
    vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    vecs[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    foreach (vecs[i]) begin
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, -1, q, r, de, bok, bdone);
      tests++;
      if (q !== vecs[i].q || r !== vecs[i].r) begin
        fails++;
        $display("FAIL directed_%0d result: q=%h r=%h, want q=%h r=%h", i, q, r, vecs[i].q, vecs[i].r);
      end
      tests++;
      if (de != LAT || !bok || bdone) begin
        fails++;
        $display("FAIL directed_%0d timing: done_edge=%0d busy_ok=%0b busy_at_done=%0b, want %0d/1/0",
                 i, de, bok, bdone, LAT);
      end
      @(posedge clk);
      #1;
      tests++;
      if (done !== 1'b0 || quotient !== vecs[i].q || remainder !== vecs[i].r) begin
        fails++;
        $display("FAIL directed_%0d hold: done=%0b q=%h r=%h, want done=0 q=%h r=%h",
                 i, done, quotient, remainder, vecs[i].q, vecs[i].r);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er;
    logic        sgn;
    int          de, sel;
    bit          bok, bdone;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      a   = $urandom;
      b   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case (sel)
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       a = 32'($urandom_range(0, 100));
        4:       b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      ref_div(sgn, a, b, eq, er);
      do_op(sgn, a, b, -1, q, r, de, bok, bdone);
      tests++;
      if (q !== eq || r !== er || de != LAT) begin
        fails++;
        $display("FAIL random_%0d s=%0b %h/%h: q=%h r=%h edge=%0d, want q=%h r=%h edge=%0d",
                 i, sgn, a, b, q, r, de, eq, er, LAT);
      end
    end
  endtask

  task automatic test_handshake();
    logic [31:0] q, r;
    int          de;
    bit          bok, bdone;
    do_op(1'b0, 32'd1000, 32'd9, 5, q, r, de, bok, bdone);
    tests++;
    if (q !== 32'd111 || r !== 32'd1 || de != LAT || !bok) begin
      fails++;
      $display("FAIL ignore_start: q=%h r=%h edge=%0d busy_ok=%0b, want q=0000006f r=00000001 edge=%0d busy_ok=1",
               q, r, de, bok, LAT);
    end
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_start_queued: busy=%0b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r;
    int          de;
    bit          bok, bdone;
    do_op(1'b1, 32'hFFFF_FF9C, 32'd3, -1, q, r, de, bok, bdone);
    tests++;
    if (q !== 32'hFFFF_FFDF || r !== 32'hFFFF_FFFF || de != LAT || done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: q=%h r=%h edge=%0d done=%0b, want q=ffffffdf r=ffffffff edge=%0d done=1",
               q, r, de, done, LAT);
    end
    // Starts on the falling edge of the done cycle.
    do_op(1'b0, 32'd12345, 32'd100, -1, q, r, de, bok, bdone);
    tests++;
    if (q !== 32'd123 || r !== 32'd45 || de != LAT || !bok) begin
      fails++;
      $display("FAIL b2b_second: q=%h r=%h edge=%0d busy_ok=%0b, want q=0000007b r=0000002d edge=%0d busy_ok=1",
               q, r, de, bok, LAT);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] q, r;
    int          de;
    bit          bok, bdone, saw_done;
    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'hFFFF;
    divisor   = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, quotient, remainder} !== 66'd0) begin
      fails++;
      $display("FAIL reset_abort_async: busy=%0b done=%0b q=%h r=%h, want all 0", busy, done, quotient, remainder);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 36; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    tests++;
    if (saw_done) begin
      fails++;
      $display("FAIL reset_abort_no_done: activity seen after abort=1, want 0");
    end
    do_op(1'b0, 32'hFFFF, 32'd3, -1, q, r, de, bok, bdone);
    tests++;
    if (q !== 32'h5555 || r !== 32'd0 || de != LAT) begin
      fails++;
      $display("FAIL reset_fresh_op: q=%h r=%h edge=%0d, want q=00005555 r=00000000 edge=%0d", q, r, de, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_handshake();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
